// File: rtl/seg_pkg.sv
// Shared constants for the segment counter: glyph table, digit maxima
// and the counter-width helper.
package seg_pkg;

  localparam logic [3:0] MAX_HEX = 4'hF;
  localparam logic [3:0] MAX_BCD = 4'd9;

  // Segment patterns indexed by nibble, bit order GFEDCBA, active-high.
  localparam logic [6:0] GLYPH [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_counter_mux_if.sv
// Board-side signals of the segment counter: key/mode/clear in, LED and
// 7-segment pins out.
interface seg_counter_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic                  key;
  logic                  mode_bcd;
  logic                  clr;
  logic [2:0]            led;
  logic                  wrap;
  logic [NUM_DIGITS-1:0] scathod;
  logic [6:0]            ssegment;

  modport master (output key, mode_bcd, clr,
                  input  led, wrap, scathod, ssegment);
  modport slave  (input  key, mode_bcd, clr,
                  output led, wrap, scathod, ssegment);
endinterface

// File: rtl/seg_counter_mux_key_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability down-counter,
// debounced level and a one-cycle press pulse on a debounced 1->0 edge.
module key_debounce
  import seg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] remain;
  logic          differ;
  logic          accept;

  // The level is accepted on the DEBOUNCE_CYCLES-th consecutive differing cycle.
  assign differ = sync2 != level;
  assign accept = differ && (remain == '0);
  assign press  = accept && !sync2;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      level  <= 1'b1;
      remain <= LOAD;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      if (!differ || accept) remain <= LOAD;
      else                   remain <= remain - CW'(1);
      if (accept) level <= sync2;
    end
  end

endmodule

// File: rtl/seg_counter_mux.sv
// Free-running multi-digit hex/BCD counter with run/pause key and a
// multiplexed, fully registered 7-segment scan driver.
module seg_counter_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int TICK_DIV        = 4194304,
  parameter int SCAN_DIV        = 65536,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  seg_counter_mux_if.slave bus
);
  localparam int TW = cnt_width(TICK_DIV);
  localparam int SW = cnt_width(SCAN_DIV);
  localparam int IW = cnt_width(NUM_DIGITS);

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [SW-1:0] scan_cnt;
  logic          scan_wrap;
  logic [IW-1:0] scan_idx;
  logic [3:0]    digit     [NUM_DIGITS];
  logic [3:0]    digit_inc [NUM_DIGITS];
  logic [3:0]    max_digit;
  logic          carry;
  logic          all_max;
  logic          mode_q;
  logic          mode_prev;
  logic          mode_chg;
  logic          press;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .key     (bus.key),
    .press   (press)
  );

  assign tick      = tick_cnt == TW'(TICK_DIV - 1);
  assign scan_wrap = scan_cnt == SW'(SCAN_DIV - 1);
  assign mode_chg  = mode_q != mode_prev;

  // Ripple carry across digits; ">=" also folds any out-of-range digit back to 0.
  always_comb begin
    max_digit = mode_q ? MAX_BCD : MAX_HEX;
    carry     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_inc[i] = digit[i];
      if (carry) digit_inc[i] = (digit[i] >= max_digit) ? 4'd0 : digit[i] + 4'd1;
      carry = carry && (digit[i] >= max_digit);
    end
    all_max = carry;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      scan_cnt  <= '0;
      scan_idx  <= '0;
      mode_q    <= 1'b0;
      mode_prev <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= '0;
      bus.led      <= 3'b001;
      bus.wrap     <= 1'b0;
      bus.scathod  <= '1;
      bus.ssegment <= '0;
    end else begin
      tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);
      mode_q    <= bus.mode_bcd;
      mode_prev <= mode_q;
      bus.wrap  <= 1'b0;

      if (bus.clr || mode_chg) begin
        for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= '0;
      end else if (tick && bus.led[0]) begin
        digit    <= digit_inc;
        bus.wrap <= all_max;
      end

      if (tick) bus.led[2] <= ~bus.led[2];
      if (press) begin
        bus.led[1] <= ~bus.led[1];
        bus.led[0] <= ~bus.led[0];
      end

      scan_cnt <= scan_wrap ? '0 : scan_cnt + SW'(1);
      if (scan_wrap)
        scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + IW'(1);
      bus.scathod  <= ~(NUM_DIGITS'(1) << scan_idx);
      bus.ssegment <= GLYPH[digit[scan_idx]];
    end
  end

endmodule

// File: tb/tb_seg_counter_mux.sv
// Self-checking bench for seg_counter_mux: directed steps plus random key,
// clear and mode activity against a value-level reference model.
module tb_seg_counter_mux;
  localparam int ND = 4;
  localparam int TD = 4;
  localparam int SD = 2;
  localparam int DC = 3;
  localparam logic [6:0] G_0 = 7'b0111111;
  localparam logic [6:0] G_1 = 7'b0000110;
  localparam logic [6:0] G_F = 7'b1110001;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  seg_counter_mux_if #(.NUM_DIGITS(ND)) bus ();
  seg_counter_mux_if #(.NUM_DIGITS(2))  bus2 ();

  seg_counter_mux #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD), .DEBOUNCE_CYCLES(DC)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  seg_counter_mux #(.NUM_DIGITS(2), .TICK_DIV(TD), .SCAN_DIV(SD), .DEBOUNCE_CYCLES(DC)) dut2 (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus2)
  );

  logic [6:0] glyph_tab [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };
  logic [3:0] scan_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int w2_cnt   = 0;
  int w2_cyc   = -1;

  // Reference model: counter held as an integer in the current radix.
  int m_value, m_base, m_tick_ph, m_scan_ph, m_idx;
  bit m_run, m_led1, m_led2, m_wrap, m_mode_q, m_mode_prev, m_deb;
  logic [3:0] m_cath;
  logic [6:0] m_seg;
  int hist [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int digit_of(input int v, input int base, input int i);
    int d = v;
    for (int k = 0; k < i; k++) d = d / base;
    return d % base;
  endfunction

  function automatic bit is_letter(input logic [6:0] s);
    for (int g = 10; g < 16; g++) if (s === glyph_tab[g]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_value = 0; m_base = 16; m_tick_ph = 0; m_scan_ph = 0; m_idx = 0;
    m_run = 1'b1; m_led1 = 1'b0; m_led2 = 1'b0; m_wrap = 1'b0;
    m_mode_q = 1'b0; m_mode_prev = 1'b0; m_deb = 1'b1;
    m_cath = 4'b1111; m_seg = 7'b0;
    hist.delete();
    for (int k = 0; k < DC + 2; k++) hist.push_back(1);
  endtask

  task automatic model_edge();
    bit tick, chg, ok;
    int nb, x, last;
    m_cath = ~(4'b0001 << m_idx);
    m_seg  = glyph_tab[digit_of(m_value, m_base, m_idx)];
    if (m_scan_ph == SD - 1) m_idx = (m_idx + 1) % ND;
    m_scan_ph = (m_scan_ph + 1) % SD;
    tick = (m_tick_ph == TD - 1);
    m_tick_ph = (m_tick_ph + 1) % TD;
    chg = (m_mode_q != m_mode_prev);
    nb = m_mode_q ? 10 : 16;
    m_wrap = 1'b0;
    if (bus.clr === 1'b1) begin
      m_value = 0; m_base = nb;
    end else if (chg) begin
      m_value = 0; m_base = nb;
    end else if (tick && m_run) begin
      m_base = nb;
      if (m_value == nb ** ND - 1) begin m_value = 0; m_wrap = 1'b1; end
      else m_value = m_value + 1;
    end
    if (tick) m_led2 = !m_led2;
    // Synchronised level lags the pin by two samples; it must hold DC samples.
    hist.push_back(int'(bus.key));
    last = hist.size() - 1;
    x  = hist[last - 2];
    ok = (x != int'(m_deb));
    for (int j = 3; j <= DC + 1; j++) if (hist[last - j] != x) ok = 1'b0;
    if (ok) begin
      m_deb = x[0];
      if (x == 0) begin m_run = !m_run; m_led1 = !m_led1; end
    end
    while (hist.size() > DC + 4) void'(hist.pop_front());
    m_mode_prev = m_mode_q;
    m_mode_q    = bus.mode_bcd;
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_edge();
    cyc++;
    @(negedge sys_clk);
    chk("led",      32'(bus.led),      32'({m_led2, m_led1, m_run}));
    chk("wrap",     32'(bus.wrap),     32'(m_wrap));
    chk("scathod",  32'(bus.scathod),  32'(m_cath));
    chk("ssegment", 32'(bus.ssegment), 32'(m_seg));
    if (bus2.wrap === 1'b1) begin w2_cnt++; w2_cyc = cyc; end
    if (cyc == 1022 || cyc == 1023) chk("inst2_ff", 32'(bus2.ssegment), 32'(G_F));
  endtask

  task automatic step_bcd();
    step();
    if (bus.scathod === 4'b1110) chk("bcd_digit0_letter", 32'(is_letter(bus.ssegment)), 32'(0));
  endtask

  task automatic press_key();
    bus.key = 1'b0; repeat (8) step();
    bus.key = 1'b1; repeat (8) step();
  endtask

  initial begin
    int hold, guard;
    bit l1;
    bus.key = 1'b1;  bus.mode_bcd = 1'b0;  bus.clr = 1'b0;
    bus2.key = 1'b1; bus2.mode_bcd = 1'b0; bus2.clr = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_led",      32'(bus.led),       32'(3'b001));
    chk("rst_wrap",     32'(bus.wrap),      32'(0));
    chk("rst_scathod",  32'(bus.scathod),   32'(4'b1111));
    chk("rst_ssegment", 32'(bus.ssegment),  32'(0));
    chk("rst2_scathod", 32'(bus2.scathod),  32'(2'b11));
    chk("rst2_led",     32'(bus2.led),      32'(3'b001));
    model_reset();
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) begin
      step();
      chk("scan_seq", 32'(bus.scathod), 32'(scan_seq[k / 2]));
    end
    while (cyc < 68) step();
    chk("led_after_17_ticks", 32'(bus.led), 32'(3'b101));
    while (cyc < 1030) step();
    chk("inst2_wrap_cycles", 32'(w2_cnt), 32'(1));
    chk("inst2_wrap_time",   32'(w2_cyc), 32'(1024));

    hold = 0;
    repeat (400) begin
      if (hold == 0) begin
        bus.key = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 7));
      end
      hold--;
      bus.clr = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 63) == 0) bus.mode_bcd = ~bus.mode_bcd;
      step();
    end
    bus.key = 1'b1; bus.clr = 1'b0; bus.mode_bcd = 1'b1;
    repeat (12) step();
    if (!m_run) press_key();

    chk("run_before_press", 32'(bus.led[0]), 32'(1));
    l1 = m_led1;
    repeat (3) begin
      bus.key = 1'b0; step(); step();
      bus.key = 1'b1; step(); step();
    end
    bus.key = 1'b0;
    repeat (4) step();
    chk("run_not_yet", 32'(bus.led[0]), 32'(1));
    step();
    chk("run_toggle_at_5", 32'(bus.led[0]), 32'(0));
    chk("led1_toggle",     32'(bus.led[1]), 32'(!l1));
    repeat (24) step();
    bus.key = 1'b1;
    repeat (10) step();
    chk("release_no_effect", 32'(bus.led[0]), 32'(0));
    bus.key = 1'b0;
    repeat (10) step();
    chk("second_press_resume", 32'(bus.led[0]), 32'(1));
    bus.key = 1'b1;
    repeat (8) step();

    bus.clr = 1'b1; step(); bus.clr = 1'b0;
    guard = 0;
    while (m_value != 99 && guard < 2000) begin step_bcd(); guard++; end
    chk("reach_0099_bound", 32'(guard < 2000), 32'(1));
    guard = 0;
    while (m_value == 99 && guard < 16) begin step_bcd(); guard++; end
    repeat (8) begin
      step_bcd();
      if (bus.scathod === 4'b1011) chk("bcd_0100_digit2", 32'(bus.ssegment), 32'(G_1));
      if (bus.scathod === 4'b0111) chk("bcd_0100_digit3", 32'(bus.ssegment), 32'(G_0));
    end
    bus.mode_bcd = 1'b0; step(); step();
    bus.mode_bcd = 1'b1; repeat (3) step();

    guard = 0;
    while (m_value != 9999 && guard < 45000) begin step_bcd(); guard++; end
    chk("reach_9999_bound", 32'(guard < 45000), 32'(1));
    while (m_tick_ph != TD - 1) step();
    bus.clr = 1'b1; step(); bus.clr = 1'b0;
    chk("clr_on_tick_wrap", 32'(bus.wrap), 32'(0));
    step();
    chk("clr_on_tick_zero", 32'(bus.ssegment), 32'(G_0));

    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_scathod",  32'(bus.scathod),  32'(4'b1111));
    chk("async_rst_ssegment", 32'(bus.ssegment), 32'(0));
    chk("async_rst_led",      32'(bus.led),      32'(3'b001));
    chk("async_rst2_scathod", 32'(bus2.scathod), 32'(2'b11));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
